conv_transpose2d: RTL and testbench
===================================

// Module: conv_transpose2d
// PURPOSE
//  Memory-mapped 2-D transposed convolution (deconvolution), used by the decoder/synthesis path to upsample feature maps.
//  Gather form: one output pixel at a time; bias + all contributing (ic,ky,kx) taps, then a single output write.
//  Bias/input/weight/output memories use the same 1-cycle-read SRAM port style as the encoder-side conv2d.
// PARAMETERS
//  IN_CHANNELS  1   input feature channels
//  OUT_CHANNELS 2   output feature channels
//  IN_HEIGHT    2   input rows;  IN_WIDTH 2 input cols
//  KERNEL_SIZE  2   square kernel edge
//  STRIDE       2   upsampling stride (>=1)
//  PADDING      0   cropped from each output edge
//  DATA_WIDTH   32  signed word width (all memories)
//  ADDR_WIDTH   16  address width (all memories)
//  Derived: OUT_H=(IN_HEIGHT-1)*STRIDE-2*PADDING+KERNEL_SIZE; OUT_W likewise.
// PORTS
//  clk          in   1   single clock, all logic on posedge
//  rst_n        in   1   synchronous, active-low reset
//  start        in   1   level; sampled in IDLE
//  done,valid   out  1   high in DONE
//  bias_addr/bias_en        out ADDR_WIDTH/1; bias_data   in DATA_WIDTH
//  input_addr/input_en      out ADDR_WIDTH/1; input_data  in DATA_WIDTH
//  weight_addr/weight_en    out ADDR_WIDTH/1; weight_data in DATA_WIDTH
//  output_addr out ADDR_WIDTH; output_data out DATA_WIDTH; output_we,output_en out 1
// BEHAVIOUR
//  Reset (rst_n==0 at posedge, any state incl. mid-run): state=IDLE, all counters, acc, *_en, output_we, done, valid = 0;
//   addr/data outputs = 0. No partial write is completed.
//  Read timing: data valid on the cycle after the cycle *_en was high; *_en is high for exactly 1 cycle per read.
//  Layouts: input[ic][iy][ix]; weight[ic][oc][ky][kx]; bias[oc]; output[oc][oy][ox], row-major.
//  Loop order: oc, oy, ox (outer->inner); per pixel: ic, ky, kx (outer->inner).
//  Tap valid iff ny=oy+PADDING-ky>=0, nx=ox+PADDING-kx>=0, ny%STRIDE==0, nx%STRIDE==0,
//   iy=ny/STRIDE<IN_HEIGHT, ix=nx/STRIDE<IN_WIDTH. Invalid taps issue no reads.
//  FSM:
//   IDLE      -> INIT when start. INIT: clear oc/oy/ox -> BIAS_RD.
//   BIAS_RD   bias_en=1, bias_addr=oc -> BIAS_CAP.
//   BIAS_CAP  acc<=sign-ext bias_data; clear ic/ky/kx -> TAP.
//   TAP       valid tap: input_en=weight_en=1 with addrs -> CAP.
//             Invalid tap: advance; last tap -> WRITE, else stay TAP (1 cycle/invalid tap).
//   CAP       register input_data, weight_data -> MAC.
//   MAC       acc<=acc+in*wt (signed); advance tap; last -> WRITE, else TAP.
//   WRITE     output_en=output_we=1 for 1 cycle, output_addr, output_data=result -> ADVANCE.
//   ADVANCE   step ox/oy/oc with wrap; all done -> DONE, else BIAS_RD.
//   DONE      done=valid=1; -> IDLE when start==0 (held start does not restart).
//  start is ignored outside IDLE/DONE.
//  Per-pixel cycles: 4 + 1*(invalid taps) + 3*(valid taps).
//  acc: signed 2*DATA_WIDTH+8 bits, cleared via bias each pixel.
// CONFIGURATION
//  CONVT_SAT_EN defined:   result = acc clamped to [-2^(DW-1), 2^(DW-1)-1].
//  CONVT_SAT_EN undefined: result = acc[DATA_WIDTH-1:0] (wraps).
// TESTING
//  T1 defaults; input=[1,2,3,4], weight oc0 all 1, bias=0
//     -> oc0 rows: 1 1 2 2 / 1 1 2 2 / 3 3 4 4 / 3 3 4 4.
//  T2 defaults; input all 1, weight oc1=[1,2,3,4], bias[1]=5
//     -> oc1 rows: 6 7 6 7 / 8 9 8 9 / 6 7 6 7 / 8 9 8 9.
//  T3 defaults -> 32 output_we pulses, each 10 cycles apart; no input/weight read issued for invalid taps.
//  T4 input=0x7FFFFFFF, weight=2, bias=0
//     -> with CONVT_SAT_EN: 0x7FFFFFFF; without: 0xFFFFFFFE.
//  T5 rst_n low for 1 cycle during 5th pixel
//     -> all outputs 0 next cycle, IDLE; restart reproduces T1 exactly.
//  T6 start held high through DONE -> done stays 1, no new writes; start low -> IDLE, done=0 next cycle.

Source files
------------

// File: rtl/conv_transpose2d.sv
// conv_transpose2d: memory-mapped 2-D transposed convolution, gather form.
//
// One output pixel is produced at a time: the accumulator is seeded with the
// bias of the current output channel, every contributing (ic, ky, kx) tap is
// multiplied and accumulated, then a single output write is issued.
// All memories are 1-cycle-read SRAM ports: data is valid the cycle after *_en.
//
// Build option: define CONVT_SAT_EN to clamp the result to the signed
// DATA_WIDTH range; otherwise the low DATA_WIDTH bits of the accumulator are
// written (wrapping).
//
// Ports:
//   clk, rst_n                  clock, synchronous active-low reset
//   start                       level request, sampled in IDLE / DONE
//   done, valid                 high while in DONE
//   bias_addr/bias_en/bias_data      bias memory read port   (bias[oc])
//   input_addr/input_en/input_data   input memory read port  (input[ic][iy][ix])
//   weight_addr/weight_en/weight_data weight memory read port (weight[ic][oc][ky][kx])
//   output_addr/output_data/output_we/output_en  output write port (output[oc][oy][ox])
module conv_transpose2d #(
  parameter int IN_CHANNELS  = 1,
  parameter int OUT_CHANNELS = 2,
  parameter int IN_HEIGHT    = 2,
  parameter int IN_WIDTH     = 2,
  parameter int KERNEL_SIZE  = 2,
  parameter int STRIDE       = 2,
  parameter int PADDING      = 0,
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic                  done,
  output logic                  valid,
  output logic [ADDR_WIDTH-1:0] bias_addr,
  output logic                  bias_en,
  input  logic [DATA_WIDTH-1:0] bias_data,
  output logic [ADDR_WIDTH-1:0] input_addr,
  output logic                  input_en,
  input  logic [DATA_WIDTH-1:0] input_data,
  output logic [ADDR_WIDTH-1:0] weight_addr,
  output logic                  weight_en,
  input  logic [DATA_WIDTH-1:0] weight_data,
  output logic [ADDR_WIDTH-1:0] output_addr,
  output logic [DATA_WIDTH-1:0] output_data,
  output logic                  output_we,
  output logic                  output_en
);

  localparam int OUT_H = (IN_HEIGHT - 1) * STRIDE - 2 * PADDING + KERNEL_SIZE;
  localparam int OUT_W = (IN_WIDTH - 1) * STRIDE - 2 * PADDING + KERNEL_SIZE;
  localparam int ACC_W = 2 * DATA_WIDTH + 8;
  localparam int PW    = 2 * DATA_WIDTH;
  localparam int CW    = 16;

  localparam logic [CW-1:0] OC_LAST = CW'(OUT_CHANNELS - 1);
  localparam logic [CW-1:0] OH_LAST = CW'(OUT_H - 1);
  localparam logic [CW-1:0] OW_LAST = CW'(OUT_W - 1);
  localparam logic [CW-1:0] IC_LAST = CW'(IN_CHANNELS - 1);
  localparam logic [CW-1:0] K_LAST  = CW'(KERNEL_SIZE - 1);

  typedef enum logic [3:0] {
    StIdle, StInit, StBiasRd, StBiasCap, StTap, StCap, StMac, StWrite, StAdvance, StDone
  } state_e;

  state_e state_q;

  logic [CW-1:0] oc_q, oy_q, ox_q, ic_q, ky_q, kx_q;
  logic signed [ACC_W-1:0]      acc_q;
  logic signed [DATA_WIDTH-1:0] in_q, wt_q;

  // A tap contributes only if it lands exactly on an input sample.
  function automatic logic tap_ok(input int oy, input int ox, input int ky, input int kx);
    int ny, nx;
    ny = oy + PADDING - ky;
    nx = ox + PADDING - kx;
    return (ny >= 0) && (nx >= 0) && (ny % STRIDE == 0) && (nx % STRIDE == 0) &&
           (ny / STRIDE < IN_HEIGHT) && (nx / STRIDE < IN_WIDTH);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] in_addr_f(input int ic, input int oy, input int ox,
                                                      input int ky, input int kx);
    int iy, ix;
    iy = (oy + PADDING - ky) / STRIDE;
    ix = (ox + PADDING - kx) / STRIDE;
    return ADDR_WIDTH'((ic * IN_HEIGHT + iy) * IN_WIDTH + ix);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] wt_addr_f(input int ic, input int oc, input int ky,
                                                      input int kx);
    return ADDR_WIDTH'(((ic * OUT_CHANNELS + oc) * KERNEL_SIZE + ky) * KERNEL_SIZE + kx);
  endfunction

  function automatic logic [ADDR_WIDTH-1:0] out_addr_f(input int oc, input int oy, input int ox);
    return ADDR_WIDTH'((oc * OUT_H + oy) * OUT_W + ox);
  endfunction

  // Next tap to visit (first tap when leaving BIAS_CAP), its validity and addresses.
  logic [CW-1:0]           nt_ic, nt_ky, nt_kx;
  logic                    nt_ok;
  logic [ADDR_WIDTH-1:0]   nt_iaddr, nt_waddr;
  logic                    last_tap;
  logic [CW-1:0]           nx_oc, nx_oy, nx_ox;
  logic                    all_done;
  logic [PW-1:0]           prod;
  logic signed [ACC_W-1:0] acc_sum, res_acc;
  logic [DATA_WIDTH-1:0]   result;

`ifdef CONVT_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX =
    {{(ACC_W - DATA_WIDTH + 1){1'b0}}, {(DATA_WIDTH - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN =
    {{(ACC_W - DATA_WIDTH + 1){1'b1}}, {(DATA_WIDTH - 1){1'b0}}};
`else
  logic unused_acc_hi;
`endif

  always_comb begin
    last_tap = (ic_q == IC_LAST) && (ky_q == K_LAST) && (kx_q == K_LAST);

    nt_ic = ic_q;
    nt_ky = ky_q;
    nt_kx = kx_q;
    if (state_q == StBiasCap) begin
      nt_ic = '0;
      nt_ky = '0;
      nt_kx = '0;
    end else if (kx_q != K_LAST) begin
      nt_kx = kx_q + CW'(1);
    end else begin
      nt_kx = '0;
      if (ky_q != K_LAST) begin
        nt_ky = ky_q + CW'(1);
      end else begin
        nt_ky = '0;
        nt_ic = ic_q + CW'(1);
      end
    end
    nt_ok    = tap_ok(int'(oy_q), int'(ox_q), int'(nt_ky), int'(nt_kx));
    nt_iaddr = in_addr_f(int'(nt_ic), int'(oy_q), int'(ox_q), int'(nt_ky), int'(nt_kx));
    nt_waddr = wt_addr_f(int'(nt_ic), int'(oc_q), int'(nt_ky), int'(nt_kx));

    nx_ox = ox_q + CW'(1);
    nx_oy = oy_q;
    nx_oc = oc_q;
    if (ox_q == OW_LAST) begin
      nx_ox = '0;
      if (oy_q == OH_LAST) begin
        nx_oy = '0;
        nx_oc = oc_q + CW'(1);
      end else begin
        nx_oy = oy_q + CW'(1);
      end
    end
    all_done = (oc_q == OC_LAST) && (oy_q == OH_LAST) && (ox_q == OW_LAST);

    // Sign-extended operands: the low PW bits of this product equal the signed product.
    prod    = {{DATA_WIDTH{in_q[DATA_WIDTH-1]}}, in_q} * {{DATA_WIDTH{wt_q[DATA_WIDTH-1]}}, wt_q};
    acc_sum = acc_q + {{(ACC_W - PW){prod[PW-1]}}, prod};
    // MAC writes straight out of the adder so the last tap needs no extra cycle.
    res_acc = (state_q == StMac) ? acc_sum : acc_q;

`ifdef CONVT_SAT_EN
    if (res_acc > SAT_MAX) begin
      result = SAT_MAX[DATA_WIDTH-1:0];
    end else if (res_acc < SAT_MIN) begin
      result = SAT_MIN[DATA_WIDTH-1:0];
    end else begin
      result = res_acc[DATA_WIDTH-1:0];
    end
`else
    result        = res_acc[DATA_WIDTH-1:0];
    unused_acc_hi = ^res_acc[ACC_W-1:DATA_WIDTH];
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      oc_q        <= '0;
      oy_q        <= '0;
      ox_q        <= '0;
      ic_q        <= '0;
      ky_q        <= '0;
      kx_q        <= '0;
      acc_q       <= '0;
      in_q        <= '0;
      wt_q        <= '0;
      done        <= 1'b0;
      valid       <= 1'b0;
      bias_en     <= 1'b0;
      bias_addr   <= '0;
      input_en    <= 1'b0;
      input_addr  <= '0;
      weight_en   <= 1'b0;
      weight_addr <= '0;
      output_en   <= 1'b0;
      output_we   <= 1'b0;
      output_addr <= '0;
      output_data <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) state_q <= StInit;
        end
        StInit: begin
          oc_q      <= '0;
          oy_q      <= '0;
          ox_q      <= '0;
          bias_en   <= 1'b1;
          bias_addr <= '0;
          state_q   <= StBiasRd;
        end
        StBiasRd: begin
          bias_en <= 1'b0;
          state_q <= StBiasCap;
        end
        StBiasCap: begin
          acc_q     <= {{(ACC_W - DATA_WIDTH){bias_data[DATA_WIDTH-1]}}, bias_data};
          ic_q      <= '0;
          ky_q      <= '0;
          kx_q      <= '0;
          input_en  <= nt_ok;
          weight_en <= nt_ok;
          if (nt_ok) begin
            input_addr  <= nt_iaddr;
            weight_addr <= nt_waddr;
          end
          state_q <= StTap;
        end
        StTap: begin
          // input_en was loaded with this tap's validity on entry to TAP.
          if (input_en) begin
            input_en  <= 1'b0;
            weight_en <= 1'b0;
            state_q   <= StCap;
          end else if (last_tap) begin
            output_en   <= 1'b1;
            output_we   <= 1'b1;
            output_addr <= out_addr_f(int'(oc_q), int'(oy_q), int'(ox_q));
            output_data <= result;
            state_q     <= StWrite;
          end else begin
            ic_q      <= nt_ic;
            ky_q      <= nt_ky;
            kx_q      <= nt_kx;
            input_en  <= nt_ok;
            weight_en <= nt_ok;
            if (nt_ok) begin
              input_addr  <= nt_iaddr;
              weight_addr <= nt_waddr;
            end
          end
        end
        StCap: begin
          in_q    <= input_data;
          wt_q    <= weight_data;
          state_q <= StMac;
        end
        StMac: begin
          acc_q <= acc_sum;
          if (last_tap) begin
            output_en   <= 1'b1;
            output_we   <= 1'b1;
            output_addr <= out_addr_f(int'(oc_q), int'(oy_q), int'(ox_q));
            output_data <= result;
            state_q     <= StWrite;
          end else begin
            ic_q      <= nt_ic;
            ky_q      <= nt_ky;
            kx_q      <= nt_kx;
            input_en  <= nt_ok;
            weight_en <= nt_ok;
            if (nt_ok) begin
              input_addr  <= nt_iaddr;
              weight_addr <= nt_waddr;
            end
            state_q <= StTap;
          end
        end
        StWrite: begin
          output_en <= 1'b0;
          output_we <= 1'b0;
          state_q   <= StAdvance;
        end
        StAdvance: begin
          if (all_done) begin
            done    <= 1'b1;
            valid   <= 1'b1;
            state_q <= StDone;
          end else begin
            oc_q      <= nx_oc;
            oy_q      <= nx_oy;
            ox_q      <= nx_ox;
            bias_en   <= 1'b1;
            bias_addr <= ADDR_WIDTH'(nx_oc);
            state_q   <= StBiasRd;
          end
        end
        StDone: begin
          // A held start must not retrigger; wait for it to drop first.
          if (!start) begin
            done    <= 1'b0;
            valid   <= 1'b0;
            state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_transpose2d.sv
// Self-checking bench for conv_transpose2d at default parameters.
// Expected outputs come from a scatter-form reference model pushed to a
// scoreboard queue and popped on each output write; spec vectors are also
// compared directly against captured output memory.
module tb_conv_transpose2d;

  localparam int NIN  = 4;
  localparam int NWT  = 8;
  localparam int NOC  = 2;
  localparam int OH   = 4;
  localparam int OW   = 4;
  localparam int NOUT = NOC * OH * OW;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        done, valid;
  logic [15:0] bias_addr, input_addr, weight_addr, output_addr;
  logic        bias_en, input_en, weight_en, output_we, output_en;
  logic [31:0] bias_data, input_data, weight_data, output_data;

  conv_transpose2d dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .done        (done),
    .valid       (valid),
    .bias_addr   (bias_addr),
    .bias_en     (bias_en),
    .bias_data   (bias_data),
    .input_addr  (input_addr),
    .input_en    (input_en),
    .input_data  (input_data),
    .weight_addr (weight_addr),
    .weight_en   (weight_en),
    .weight_data (weight_data),
    .output_addr (output_addr),
    .output_data (output_data),
    .output_we   (output_we),
    .output_en   (output_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] bias_mem [65536];
  logic [31:0] in_mem   [65536];
  logic [31:0] wt_mem   [65536];
  logic [31:0] out_cap  [65536];

  always @(posedge clk) begin
    if (bias_en)   bias_data   <= bias_mem[bias_addr];
    if (input_en)  input_data  <= in_mem[input_addr];
    if (weight_en) weight_data <= wt_mem[weight_addr];
  end

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
  } wr_t;
  wr_t sb[$];

  typedef struct {
    int inp [NIN];
    int wt  [NWT];
    int bias[NOC];
    int exp_oc;
    int exp_v [OH*OW];
  } vec_t;
  vec_t vecs [5];

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_we = -1;
  int n_bias = 0, n_in = 0, n_wt = 0, n_wr = 0;
  logic prev_in = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h", name, act, req);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (bias_en)   n_bias++;
      if (input_en)  n_in++;
      if (weight_en) n_wt++;
      if (input_en && prev_in) chk("input_en_width", 32'(input_en), 32'd0);
      prev_in = input_en;
      if (output_we) begin
        wr_t w;
        n_wr++;
        chk("output_en_with_we", 32'(output_en), 32'd1);
        out_cap[output_addr] = output_data;
        if (sb.size() == 0) begin
          chk("unexpected_write", 32'(output_addr), 32'hFFFF_FFFF);
        end else begin
          w = sb.pop_front();
          chk("write_addr", 32'(output_addr), 32'(w.addr));
          chk("write_data", output_data, w.data);
        end
        if (last_we >= 0) chk("write_spacing", 32'(cyc - last_we), 32'd10);
        last_we = cyc;
      end
    end else begin
      prev_in = 1'b0;
    end
  end

  // Scatter-form reference: each input sample spreads over its kernel footprint.
  task automatic load_and_model(input int idx);
    longint acc [NOUT];
    wr_t w;
    for (int i = 0; i < NIN; i++) in_mem[i] = vecs[idx].inp[i];
    for (int i = 0; i < NWT; i++) wt_mem[i] = vecs[idx].wt[i];
    for (int i = 0; i < NOC; i++) bias_mem[i] = vecs[idx].bias[i];
    for (int oc = 0; oc < NOC; oc++)
      for (int p = 0; p < OH*OW; p++) acc[oc*OH*OW + p] = longint'(vecs[idx].bias[oc]);
    for (int iy = 0; iy < 2; iy++)
      for (int ix = 0; ix < 2; ix++)
        for (int oc = 0; oc < NOC; oc++)
          for (int ky = 0; ky < 2; ky++)
            for (int kx = 0; kx < 2; kx++) begin
              int oy, ox;
              oy = iy * 2 + ky;
              ox = ix * 2 + kx;
              if (oy < OH && ox < OW)
                acc[(oc*OH + oy)*OW + ox] += longint'(vecs[idx].inp[iy*2 + ix]) *
                                             longint'(vecs[idx].wt[oc*4 + ky*2 + kx]);
            end
    sb.delete();
    for (int a = 0; a < NOUT; a++) begin
      longint v;
      v = acc[a];
`ifdef CONVT_SAT_EN
      if (v > SMAX) v = SMAX;
      if (v < SMIN) v = SMIN;
`endif
      w.addr = 16'(a);
      w.data = v[31:0];
      sb.push_back(w);
    end
  endtask

  task automatic wait_done(output logic ok);
    int t;
    t = 0;
    while (!done && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    ok = done;
  endtask

  task automatic run_vec(input int idx);
    logic ok;
    load_and_model(idx);
    n_bias = 0; n_in = 0; n_wt = 0;
    last_we = -1;
    start = 1'b1;
    wait_done(ok);
    chk("done_reached", 32'(ok), 32'd1);
    chk("valid_in_done", 32'(valid), 32'd1);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    chk("bias_reads", 32'(n_bias), 32'd32);
    chk("input_reads", 32'(n_in), 32'd32);
    chk("weight_reads", 32'(n_wt), 32'd32);
    if (vecs[idx].exp_oc >= 0)
      for (int i = 0; i < OH*OW; i++)
        chk($sformatf("vec%0d_px%0d", idx, i), out_cap[vecs[idx].exp_oc*OH*OW + i],
            32'(vecs[idx].exp_v[i]));
    // Held start through DONE: no restart, done stays high.
    repeat (15) begin @(posedge clk); #1; end
    chk("done_held", 32'(done), 32'd1);
    start = 1'b0;
    @(posedge clk); #1;
    chk("done_clear", 32'(done), 32'd0);
    chk("valid_clear", 32'(valid), 32'd0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_done"}, 32'({done, valid}), 32'd0);
    chk({tag, "_ens"}, 32'({bias_en, input_en, weight_en, output_en, output_we}), 32'd0);
    chk({tag, "_addrs"}, 32'(bias_addr | input_addr | weight_addr | output_addr), 32'd0);
    chk({tag, "_odata"}, output_data, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    logic ok;
    vecs[0].inp = '{1, 2, 3, 4};
    vecs[0].wt = '{1, 1, 1, 1, 0, 0, 0, 0};
    vecs[0].bias = '{0, 0};
    vecs[0].exp_oc = 0;
    vecs[0].exp_v = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};

    vecs[1].inp = '{1, 1, 1, 1};
    vecs[1].wt = '{0, 0, 0, 0, 1, 2, 3, 4};
    vecs[1].bias = '{0, 5};
    vecs[1].exp_oc = 1;
    vecs[1].exp_v = '{6, 7, 6, 7, 8, 9, 8, 9, 6, 7, 6, 7, 8, 9, 8, 9};

    vecs[2].inp = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF};
    vecs[2].wt = '{2, 2, 2, 2, 2, 2, 2, 2};
    vecs[2].bias = '{0, 0};
    vecs[2].exp_oc = 0;
    for (int i = 0; i < OH*OW; i++)
`ifdef CONVT_SAT_EN
      vecs[2].exp_v[i] = 32'h7FFF_FFFF;
`else
      vecs[2].exp_v[i] = 32'hFFFF_FFFE;
`endif

    vecs[3].inp = '{-3, 5, -7, 2};
    vecs[3].wt = '{4, -1, 2, 3, -5, 6, 0, -8};
    vecs[3].bias = '{-10, 100};
    vecs[3].exp_oc = -1;
    vecs[3].exp_v = '{default: 0};

    for (int i = 0; i < NIN; i++) vecs[4].inp[i] = int'($urandom());
    for (int i = 0; i < NWT; i++) vecs[4].wt[i] = int'($urandom());
    for (int i = 0; i < NOC; i++) vecs[4].bias[i] = int'($urandom());
    vecs[4].exp_oc = -1;
    vecs[4].exp_v = '{default: 0};

    rst_n = 1'b0;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_outputs_zero("reset");

    for (int v = 0; v < 5; v++) run_vec(v);

    // Reset in the middle of the 5th pixel, then rerun vector 0.
    load_and_model(0);
    n_wr = 0;
    last_we = -1;
    start = 1'b1;
    t = 0;
    while (n_wr < 4 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    chk("mid_run_progress", 32'(n_wr), 32'd4);
    repeat (3) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    sb.delete();
    chk_outputs_zero("midrun_reset");
    repeat (5) begin @(posedge clk); #1; end
    chk("idle_after_reset_writes", 32'(n_wr), 32'd4);
    chk_outputs_zero("idle_after_reset");
    run_vec(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
